spi_mem_fsm: RTL and testbench
==============================

SPI_MEM_FSM -- requirements
Module: spi_mem_fsm

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning serial frame length in bits (address+R/W frame and data frame).
REQ-002 The module SHALL have parameter CNT_W, default 4, meaning bit-counter width; it SHALL satisfy 2^CNT_W > DATA_W.
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 cs_n  input  1  conditioned (synchronized, debounced) chip select, active low.
REQ-006 sclk_posedge  input  1  one-clk pulse marking a conditioned SCLK rising edge.
REQ-007 rw_bit  input  1  shift-register parallelOut[0]; 1 = read, 0 = write.
REQ-008 sr_mode  output  2  shift-register mode: HOLD=2'b00, LEFT=2'b01, RIGHT=2'b10, PLOAD=2'b11.
REQ-009 addr_we  output  1  address-latch write enable, one clk pulse.
REQ-010 dm_we  output  1  data-memory write enable, one clk pulse.
REQ-011 miso_buf_en  output  1  MISO tri-state buffer enable.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_MEM, DONE.
REQ-014 Bit counter SHALL clear on every state entry and increment by 1 on each clk where sclk_posedge=1 in GET_ADDR, READ_SHIFT or WRITE_SHIFT.
REQ-015 IDLE: sr_mode=HOLD, all enables 0; cs_n=0 at a clk edge -> GET_ADDR next cycle.
REQ-016 GET_ADDR: sr_mode=LEFT; on the clk where counter=DATA_W-1 and sclk_posedge=1 -> GOT_ADDR.
REQ-017 GOT_ADDR: exactly 1 clk; sr_mode=HOLD, addr_we=1; rw_bit=1 -> READ_LOAD, rw_bit=0 -> WRITE_SHIFT.
REQ-018 READ_LOAD: exactly 1 clk; sr_mode=PLOAD, miso_buf_en=1 -> READ_SHIFT.
REQ-019 READ_SHIFT: sr_mode=LEFT, miso_buf_en=1; after DATA_W sclk_posedge pulses -> DONE.
REQ-020 WRITE_SHIFT: sr_mode=LEFT, miso_buf_en=0; after DATA_W sclk_posedge pulses -> WRITE_MEM.
REQ-021 WRITE_MEM: exactly 1 clk; sr_mode=HOLD, dm_we=1 -> DONE.
REQ-022 DONE: sr_mode=HOLD, all enables 0; remains until cs_n=1, then -> IDLE.
REQ-023 All outputs SHALL be registered-state Moore decodes; no output depends combinationally on inputs.
REQ-024 cs_n=1 sampled in any state other than WRITE_MEM SHALL force IDLE on the next clk and abort the transaction with no addr_we or dm_we pulse.
REQ-025 cs_n=1 sampled in WRITE_MEM SHALL still complete the dm_we pulse, then go to IDLE (write is committed once all data bits are shifted).
REQ-026 sclk_posedge in GOT_ADDR, READ_LOAD, WRITE_MEM, DONE or IDLE SHALL be ignored and SHALL NOT increment the counter.
REQ-027 addr_we and dm_we SHALL never be high in the same cycle; each SHALL pulse at most once per cs_n low period.
REQ-028 A new transaction SHALL require cs_n to return high; holding cs_n low after DONE SHALL NOT restart GET_ADDR.

Reset
REQ-029 resetn=0 SHALL immediately (asynchronously) force IDLE, counter=0, sr_mode=HOLD, addr_we=0, dm_we=0, miso_buf_en=0, busy=0.
REQ-030 Release of resetn SHALL take effect at the next rising clk; with cs_n=0 already low at release, FSM SHALL enter GET_ADDR on the first clk edge after release.

Verification
REQ-031 Read: cs_n=0, 8 sclk_posedge pulses, rw_bit=1 -> one addr_we pulse, then sr_mode=PLOAD for 1 clk, miso_buf_en=1 for exactly 8 pulses, DONE, dm_we never 1.
REQ-032 Write: cs_n=0, 8 pulses, rw_bit=0, 8 more pulses -> addr_we pulse, sr_mode=LEFT throughout shifting, exactly one dm_we pulse immediately after 8th data pulse, miso_buf_en stays 0.
REQ-033 Abort: cs_n=1 after 5 address pulses -> IDLE next clk, no addr_we; then cs_n=0 and full read completes normally.
REQ-034 Mid-op reset: resetn=0 during WRITE_SHIFT after 3 pulses -> all outputs zero/HOLD instantly, no dm_we, busy=0.
REQ-035 Stuck CS: cs_n held 0 after DONE with 10 extra sclk_posedge pulses -> remains DONE, sr_mode=HOLD, no enable pulses.
REQ-036 Spurious edges: sclk_posedge in GOT_ADDR and READ_LOAD cycles -> counter unchanged; READ_SHIFT still spans exactly 8 counted pulses.

Source files
------------

// File: rtl/spi_mem_fsm.sv
// SPI memory slave control FSM: sequences the shift register, address
// latch, data-memory write and MISO buffer for one SPI transaction
// (address+R/W frame followed by a read or write data frame).
module spi_mem_fsm #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cs_n,
    input  logic       sclk_posedge,
    input  logic       rw_bit,
    output logic [1:0] sr_mode,
    output logic       addr_we,
    output logic       dm_we,
    output logic       miso_buf_en,
    output logic       busy
);

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_LEFT  = 2'b01;
    localparam logic [1:0] SR_PLOAD = 2'b11;

    // Counter value on which the final bit of a frame arrives.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        GOT_ADDR    = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SHIFT  = 3'd4,
        WRITE_SHIFT = 3'd5,
        WRITE_MEM   = 3'd6,
        DONE        = 3'd7
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             counting;
    logic             last_pulse;

    // Only the three shifting states consume SCLK edges; edges elsewhere are ignored.
    assign counting   = (state == GET_ADDR) || (state == READ_SHIFT) || (state == WRITE_SHIFT);
    assign last_pulse = sclk_posedge && (bit_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit counter: restarts on every state change, counts SCLK edges while shifting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt <= '0;
        end else if (state_next != state) begin
            bit_cnt <= '0;
        end else if (counting && sclk_posedge) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Next-state logic and Moore output decode of the registered state.
    always_comb begin
        state_next  = state;
        sr_mode     = SR_HOLD;
        addr_we     = 1'b0;
        dm_we       = 1'b0;
        miso_buf_en = 1'b0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (!cs_n) state_next = GET_ADDR;
            end
            GET_ADDR: begin
                sr_mode = SR_LEFT;
                if (cs_n)            state_next = IDLE;
                else if (last_pulse) state_next = GOT_ADDR;
            end
            GOT_ADDR: begin
                addr_we = 1'b1;
                if (cs_n)        state_next = IDLE;
                else if (rw_bit) state_next = READ_LOAD;
                else             state_next = WRITE_SHIFT;
            end
            READ_LOAD: begin
                sr_mode     = SR_PLOAD;
                miso_buf_en = 1'b1;
                state_next  = cs_n ? IDLE : READ_SHIFT;
            end
            READ_SHIFT: begin
                sr_mode     = SR_LEFT;
                miso_buf_en = 1'b1;
                if (cs_n)            state_next = IDLE;
                else if (last_pulse) state_next = DONE;
            end
            WRITE_SHIFT: begin
                sr_mode = SR_LEFT;
                if (cs_n)            state_next = IDLE;
                else if (last_pulse) state_next = WRITE_MEM;
            end
            WRITE_MEM: begin
                // All data bits are in, so the write commits even if CS rises now.
                dm_we      = 1'b1;
                state_next = cs_n ? IDLE : DONE;
            end
            DONE: begin
                // Wait for CS to rise so a held-low CS cannot start a second transaction.
                if (cs_n) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_mem_fsm.sv
// Directed testbench for spi_mem_fsm: read, write, abort, reset, stuck CS
// and spurious SCLK edge scenarios.
module tb_spi_mem_fsm;

    logic       clk;
    logic       resetn;
    logic       cs_n;
    logic       sclk_posedge;
    logic       rw_bit;
    logic [1:0] sr_mode;
    logic       addr_we;
    logic       dm_we;
    logic       miso_buf_en;
    logic       busy;

    logic [5:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output words {busy, miso_buf_en, dm_we, addr_we, sr_mode[1:0]}
    localparam logic [5:0] E_IDLE   = 6'h00;
    localparam logic [5:0] E_SHIFTW = 6'h21; // GET_ADDR / WRITE_SHIFT
    localparam logic [5:0] E_GOTA   = 6'h24;
    localparam logic [5:0] E_RLOAD  = 6'h33;
    localparam logic [5:0] E_RSHIFT = 6'h31;
    localparam logic [5:0] E_WMEM   = 6'h28;
    localparam logic [5:0] E_DONE   = 6'h20;

    spi_mem_fsm #(.DATA_W(8), .CNT_W(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cs_n         (cs_n),
        .sclk_posedge (sclk_posedge),
        .rw_bit       (rw_bit),
        .sr_mode      (sr_mode),
        .addr_we      (addr_we),
        .dm_we        (dm_we),
        .miso_buf_en  (miso_buf_en),
        .busy         (busy)
    );

    assign obs = {busy, miso_buf_en, dm_we, addr_we, sr_mode};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] observed, input logic [5:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    // n one-clk SCLK pulses separated by an idle clk; the state must stay put throughout.
    task automatic pulses(input int n, input logic [5:0] expected, input string tag);
        for (int i = 0; i < n; i++) begin
            sclk_posedge = 1'b1;
            tick();
            sclk_posedge = 1'b0;
            chk(tag, obs, expected);
            tick();
            chk(tag, obs, expected);
        end
    endtask

    // One SCLK pulse, checking the state that follows it.
    task automatic last_pulse(input logic [5:0] expected, input string tag);
        sclk_posedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        chk(tag, obs, expected);
    endtask

    task automatic full_read(input string tag);
        rw_bit = 1'b1;
        pulses(7, E_SHIFTW, {tag, "_addr"});
        last_pulse(E_GOTA, {tag, "_gotaddr"});
        tick();
        chk({tag, "_rload"}, obs, E_RLOAD);
        tick();
        chk({tag, "_rshift0"}, obs, E_RSHIFT);
        pulses(7, E_RSHIFT, {tag, "_rshift"});
        last_pulse(E_DONE, {tag, "_done"});
    endtask

    initial begin
        resetn       = 1'b0;
        cs_n         = 1'b1;
        sclk_posedge = 1'b0;
        rw_bit       = 1'b0;

        // Reset state, before any clock edge
        #1;
        chk("reset_async", obs, E_IDLE);
        tick();
        tick();
        chk("reset_held", obs, E_IDLE);

        // Release with cs_n already low: GET_ADDR on the first edge
        cs_n   = 1'b0;
        resetn = 1'b1;
        tick();
        chk("release_getaddr", obs, E_SHIFTW);

        // Read with spurious SCLK edges in GOT_ADDR and READ_LOAD
        rw_bit = 1'b1;
        pulses(7, E_SHIFTW, "rd_addr");
        last_pulse(E_GOTA, "rd_gotaddr");
        sclk_posedge = 1'b1;
        tick();
        chk("rd_rload_spur", obs, E_RLOAD);
        tick();
        chk("rd_rshift_spur", obs, E_RSHIFT);
        sclk_posedge = 1'b0;
        pulses(7, E_RSHIFT, "rd_rshift");
        last_pulse(E_DONE, "rd_done");

        // Stuck CS: DONE ignores further pulses
        pulses(10, E_DONE, "stuck_cs");
        cs_n = 1'b1;
        tick();
        chk("rd_idle", obs, E_IDLE);

        // Write
        cs_n   = 1'b0;
        rw_bit = 1'b0;
        tick();
        chk("wr_getaddr", obs, E_SHIFTW);
        pulses(7, E_SHIFTW, "wr_addr");
        last_pulse(E_GOTA, "wr_gotaddr");
        tick();
        chk("wr_wshift0", obs, E_SHIFTW);
        pulses(7, E_SHIFTW, "wr_wshift");
        last_pulse(E_WMEM, "wr_wmem");
        tick();
        chk("wr_done", obs, E_DONE);
        cs_n = 1'b1;
        tick();
        chk("wr_idle", obs, E_IDLE);

        // Write with cs_n rising during WRITE_MEM: pulse completes, then IDLE
        cs_n = 1'b0;
        tick();
        pulses(7, E_SHIFTW, "wc_addr");
        last_pulse(E_GOTA, "wc_gotaddr");
        tick();
        pulses(7, E_SHIFTW, "wc_wshift");
        last_pulse(E_WMEM, "wc_wmem");
        cs_n = 1'b1;
        tick();
        chk("wc_idle", obs, E_IDLE);

        // Abort after 5 address pulses, then a complete read
        cs_n = 1'b0;
        tick();
        chk("ab_getaddr", obs, E_SHIFTW);
        pulses(5, E_SHIFTW, "ab_addr");
        cs_n = 1'b1;
        tick();
        chk("ab_idle", obs, E_IDLE);
        tick();
        chk("ab_idle_hold", obs, E_IDLE);
        cs_n = 1'b0;
        tick();
        chk("ab2_getaddr", obs, E_SHIFTW);
        full_read("ab2");
        cs_n = 1'b1;
        tick();
        chk("ab2_idle", obs, E_IDLE);

        // Mid-write reset after 3 data pulses
        cs_n   = 1'b0;
        rw_bit = 1'b0;
        tick();
        pulses(7, E_SHIFTW, "mr_addr");
        last_pulse(E_GOTA, "mr_gotaddr");
        tick();
        pulses(3, E_SHIFTW, "mr_wshift");
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_async", obs, E_IDLE);
        cs_n = 1'b1;
        tick();
        tick();
        chk("mr_held", obs, E_IDLE);
        resetn = 1'b1;
        tick();
        chk("mr_release", obs, E_IDLE);

        // Fresh transaction after reset starts from bit 0
        cs_n = 1'b0;
        tick();
        chk("post_getaddr", obs, E_SHIFTW);
        full_read("post");
        cs_n = 1'b1;
        tick();
        chk("post_idle", obs, E_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
